// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: Funct3 access encodings,
// access-size classification and the request FSM state type.
// Optional build macro used by this slice: MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Undefined encodings fall back to a full-word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-lane extraction and sign/zero extension.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;

  // Pick the addressed lane and extend it to the full word.
  always_comb begin
    byte_v = rdata[7:0];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sgn    = ~funct3[2];
    data   = rdata;
    case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (f3_size(funct3))
      SZ_B:    data = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_H:    data = {{16{sgn & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: latches one access, holds a data-memory
// request until ack, registers extended load data and stalls upstream.
// Optional build macro: MISALIGN_TRAP_EN (adds MisalignM trap output).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ack,
  output logic [DATA_WIDTH-1:0] RD,
`ifdef MISALIGN_TRAP_EN
  output logic                  MisalignM,
`endif
  output logic                  StallM
);

  lsu_state_e  state_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        access;

  assign access = MemReadM | MemWriteM;

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WriteDataM;
    case (f3_size(Funct3M))
      SZ_B: begin
        st_be    = 4'b0001 << ALUResultM[1:0];
        st_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        st_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = WriteDataM;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  always_comb begin
    misalign = 1'b0;
    case (f3_size(Funct3M))
      SZ_H:    misalign = ALUResultM[0];
      SZ_W:    misalign = |ALUResultM[1:0];
      default: misalign = 1'b0;
    endcase
  end
`endif

  lsu_load_align u_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .data    (ld_data)
  );

  // Request FSM with registered memory-request, stall and load-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      RD         <= '0;
      StallM     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      addr_lo_q  <= '0;
      f3_q       <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignM  <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      MisalignM <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (access) begin
`ifdef MISALIGN_TRAP_EN
            if (misalign) MisalignM <= 1'b1;
            else
`endif
            begin
              dmem_req   <= 1'b1;
              dmem_we    <= MemWriteM;
              dmem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
              dmem_be    <= st_be;
              dmem_wdata <= st_wdata;
              addr_lo_q  <= ALUResultM[1:0];
              f3_q       <= Funct3M;
              StallM     <= 1'b1;
              state_q    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            if (!dmem_we) RD <= ld_data;
            dmem_req <= 1'b0;
            StallM   <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table,
// hand-written reset/alignment sequences and randomized accesses
// checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] RD;
  logic        StallM;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_model;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .RD         (RD),
`ifdef MISALIGN_TRAP_EN
    .MisalignM  (MisalignM),
`endif
    .StallM     (StallM)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wt;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model, expressed in terms of access size in bytes.
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int n = size_bytes(f3);
    int off = (n == 4) ? 0 : (a % 4) / n * n;
    logic [3:0] mask = (n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111;
    return mask << off;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
    int n = size_bytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
    int n = size_bytes(f3);
    int off = (n == 4) ? 0 : (a % 4) / n * n;
    logic [31:0] v = rdat >> (8 * off);
    bit sgn = (f3 < 3'd4);
    if (n == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    int n = size_bytes(f3);
    return (a % n) != 0;
  endfunction

  // One complete access: accept, BUSY for wt wait cycles plus ack, DONE, IDLE.
  task automatic run(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int wt,
                     input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                     input string tag);
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;
    int          n, stalls;
    bit          stable, mis;
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = model_mis(f3, addr);
`endif
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wdata;
    @(negedge clk);
    if (mis) begin
      MemReadM = 1'b0; MemWriteM = 1'b0;
`ifdef MISALIGN_TRAP_EN
      check({tag, "_mis_pulse"}, 32'(MisalignM), 32'd1);
      check({tag, "_mis_noreq"}, 32'(dmem_req), 32'd0);
      check({tag, "_mis_stall"}, 32'(StallM), 32'd0);
      @(negedge clk);
      check({tag, "_mis_onecyc"}, 32'(MisalignM), 32'd0);
      check({tag, "_mis_noreq2"}, 32'(dmem_req), 32'd0);
      check({tag, "_mis_rd"}, RD, erd);
`endif
      return;
    end
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_stall"}, 32'(StallM), 32'd1);
    check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    check({tag, "_we"}, 32'(dmem_we), 32'(wr));
    check({tag, "_be"}, 32'(dmem_be), 32'(ebe));
    if (wr) check({tag, "_wdata"}, dmem_wdata, ewd);
    cap_addr = dmem_addr; cap_wd = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
    stable = 1'b1; n = 0; stalls = 0;
    while (dmem_req && n < 64) begin
      if (StallM) stalls++;
      if (dmem_addr !== cap_addr || dmem_wdata !== cap_wd || dmem_be !== cap_be ||
          dmem_we !== cap_we) stable = 1'b0;
      dmem_ack   = (n == wt);
      dmem_rdata = (n == wt) ? rdata : $urandom;
      MemReadM   = 1'($urandom); MemWriteM = 1'($urandom);
      Funct3M    = 3'($urandom); ALUResultM = $urandom; WriteDataM = $urandom;
      n++;
      @(negedge clk);
    end
    // DONE cycle: a stray ack with different data must be ignored.
    dmem_ack = 1'b1; dmem_rdata = ~rdata; MemReadM = 1'b0; MemWriteM = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'(wt + 1));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(wt + 1));
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_done_stall"}, 32'(StallM), 32'd0);
    check({tag, "_done_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_rd"}, RD, erd);
    @(negedge clk);
    check({tag, "_idle_rd"}, RD, erd);
    check({tag, "_idle_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_idle_stall"}, 32'(StallM), 32'd0);
    dmem_ack = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        2, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1, 4'b1000, 32'h0, 32'hFFFFFF80};
    tbl[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 0, 4'b1000, 32'h0, 32'h00000080};
    tbl[3]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 0, 4'b1100, 32'h0, 32'hFFFF80FF};
    tbl[4]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80FF1234, 3, 4'b1100, 32'h0, 32'h000080FF};
    tbl[5]  = '{0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0,        0, 4'b0010, 32'hABABABAB, 32'h000080FF};
    tbl[6]  = '{1, 0, 3'b010, 32'h204, 32'h0,        32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'hCAFEF00D};
    tbl[7]  = '{0, 1, 3'b001, 32'h302, 32'h0000BEEF, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'hCAFEF00D};
    tbl[8]  = '{1, 1, 3'b010, 32'h040, 32'h11223344, 32'h55555555, 0, 4'b1111, 32'h11223344, 32'hCAFEF00D};
    tbl[9]  = '{1, 0, 3'b011, 32'h008, 32'h0,        32'h89ABCDEF, 0, 4'b1111, 32'h0, 32'h89ABCDEF};
    tbl[10] = '{1, 0, 3'b000, 32'h000, 32'h0,        32'h0000007F, 1, 4'b0001, 32'h0, 32'h0000007F};
    tbl[11] = '{1, 0, 3'b001, 32'h100, 32'h0,        32'h12348001, 0, 4'b0011, 32'h0, 32'hFFFF8001};

    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = '0; ALUResultM = '0; WriteDataM = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_rd", RD, 32'h0);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_model = 32'h0;

    // Idle with no access: nothing moves, ack ignored.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      check("idle_req", 32'(dmem_req), 32'd0);
      check("idle_stall", 32'(StallM), 32'd0);
      check("idle_rd", RD, 32'h0);
    end
    dmem_ack = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
          tbl[i].wt, tbl[i].ebe, tbl[i].ewd, tbl[i].erd, $sformatf("vec%0d", i));
      rd_model = tbl[i].erd;
    end

    // Low address bits beyond the access size.
`ifdef MISALIGN_TRAP_EN
    run(1, 0, 3'b010, 32'h102, 32'h0, 32'h13579BDF, 0, 4'b1111, 32'h0, rd_model, "lw_unal");
    run(1, 0, 3'b001, 32'h103, 32'h0, 32'hA5A5C3C3, 0, 4'b1100, 32'h0, rd_model, "lh_unal");
`else
    run(1, 0, 3'b010, 32'h102, 32'h0, 32'h13579BDF, 0, 4'b1111, 32'h0, 32'h13579BDF, "lw_unal");
    run(1, 0, 3'b001, 32'h103, 32'h0, 32'hA5A5C3C3, 0, 4'b1100, 32'h0, 32'hFFFFA5A5, "lh_unal");
    rd_model = 32'hFFFFA5A5;
`endif

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] a, wd, rdat, erd;
      int wt;
      rd = 1'($urandom); wr = 1'($urandom);
      f3 = 3'($urandom); a = $urandom; wd = $urandom; rdat = $urandom;
      wt = $urandom_range(0, 3);
      if (!rd && !wr) begin
        @(negedge clk);
        check("rnd_idle_req", 32'(dmem_req), 32'd0);
        check("rnd_idle_rd", RD, rd_model);
        continue;
      end
      erd = rd_model;
`ifdef MISALIGN_TRAP_EN
      if (!wr && !model_mis(f3, a)) erd = model_ld(f3, a, rdat);
`else
      if (!wr) erd = model_ld(f3, a, rdat);
`endif
      run(rd, wr, f3, a, wd, rdat, wt, model_be(f3, a), model_wd(f3, wd), erd,
          $sformatf("rnd%0d", i));
      rd_model = erd;
    end

    // Reset in the middle of BUSY, then a late ack for the aborted request.
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h500;
    @(negedge clk);
    MemReadM = 1'b0;
    check("abort_req_before", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req", 32'(dmem_req), 32'd0);
    check("abort_stall", 32'(StallM), 32'd0);
    check("abort_rd", RD, 32'h0);
    check("abort_be", 32'(dmem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("late_ack_rd", RD, 32'h0);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_stall", 32'(StallM), 32'd0);
    @(negedge clk);
    check("late_ack_rd2", RD, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports MemReadM  in  1  load request, and MemWriteM  in  1  store request.
REQ-005 SHALL have port Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-006 SHALL have ports ALUResultM  in  32  byte address, and WriteDataM  in  32  store data.
REQ-007 SHALL have ports dmem_req  out  1, dmem_we  out  1, dmem_addr  out  32, dmem_wdata  out  32, dmem_be  out  4, as the data-memory request.
REQ-008 SHALL have ports dmem_rdata  in  32  and dmem_ack  in  1  (one-cycle completion pulse).
REQ-009 SHALL have ports RD  out  32  extended load data (feeds the MEM/WB register), and StallM  out  1  freeze upstream stages.

Function
REQ-010 SHALL implement FSM IDLE, BUSY, DONE.
REQ-011 IDLE with MemReadM or MemWriteM SHALL latch address, we, be, wdata and Funct3M, assert StallM, and go to BUSY; store wins if both are set.
REQ-012 IDLE with no access SHALL keep StallM=0 and dmem_req=0, with RD unchanged.
REQ-013 BUSY SHALL hold dmem_req=1 with stable latched request fields and StallM=1; inputs changing meanwhile are ignored.
REQ-014 BUSY with dmem_ack SHALL register load data into RD (loads only) and go to DONE.
REQ-015 DONE SHALL drive StallM=0 for exactly one cycle and return to IDLE unconditionally, so the held instruction is never re-issued.
REQ-016 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-017 Minimum access latency SHALL be 3 cycles (accept, BUSY+ack, DONE); each wait cycle adds one.
REQ-018 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_we=1 for stores only.
REQ-019 Store lanes SHALL be: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011<<{addr[1],0}, wdata=half replicated x2; SW be=1111.
REQ-020 Loads SHALL be: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0] or addr[1]; LW passes the full word.
REQ-021 Undefined Funct3M (011,110,111) SHALL be treated as word access.
REQ-022 Stores SHALL NOT modify RD.

Reset
REQ-023 rst_n low SHALL force state=IDLE, RD=0, StallM=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0 immediately, including mid-BUSY.
REQ-024 An ack for a request aborted by reset SHALL be ignored.

Configuration
REQ-025 Macro MISALIGN_TRAP_EN SHALL add port MisalignM  out  1.
REQ-026 With MISALIGN_TRAP_EN, halfword at odd address or word with addr[1:0]!=0 SHALL issue no request, pulse MisalignM for one cycle, keep StallM=0, and leave RD unchanged.
REQ-027 Without MISALIGN_TRAP_EN, the port SHALL be absent and low address bits beyond the access size SHALL be ignored (LH uses addr[1], LW ignores addr[1:0]).

Structure
REQ-028 Package lsu_pkg SHALL hold the Funct3 encodings as localparams and the FSM state enum typedef.
REQ-029 Lane extract/extend SHALL be a combinational sub-module lsu_load_align.

Verification
REQ-030 Reset: rst_n=0 for any state -> RD=0, StallM=0, dmem_req=0.
REQ-031 SW 0xDEADBEEF to 0x100, ack 2 cycles after req -> dmem_addr=0x100, be=1111, StallM high 3 cycles, then low 1.
REQ-032 LB addr 0x103, rdata 0x80FF1234 -> RD=0xFFFFFF80; LBU -> RD=0x00000080.
REQ-033 LH addr 0x102, rdata 0x80FF1234 -> RD=0xFFFF80FF; LHU -> RD=0x000080FF.
REQ-034 SB 0x000000AB to 0x201 -> be=0010, wdata=0xABABABAB, RD unchanged.
REQ-035 Reset asserted in BUSY, then a late ack -> req drops at once and the ack is ignored; with MISALIGN_TRAP_EN, LW at 0x102 -> MisalignM=1 one cycle, no dmem_req.
